hs_arith_umin_slot_scheduler: RTL and testbench

HS_ARITH_UMIN_SLOT_SCHEDULER -- requirements
Module: hs_arith_umin_slot_scheduler

---
 rtl/hs_arith_umin_slot_scheduler.sv | 150 +++++++++++++++
 tb/tb_hs_arith_umin_slot_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_arith_umin_slot_scheduler.sv
// -----------------------------------------------------------------------------
// hs_arith_umin_slot_scheduler
//
// Small slot-based scheduler that always offers the entry holding the
// smallest unsigned key. Each slot keeps an occupied flag, a key and a
// user payload. A push lands in the lowest free slot. A combinational
// minimum selector scans the registered slots and drives the output side.
// The selection therefore reflects only state that is already registered.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   flush      : synchronous clear of all occupied flags (keys/payloads kept)
//   in_valid   : push request
//   in_ready   : push accept (not full and no flush)
//   in_data    : key to store
//   in_aux     : payload stored with the key
//   out_valid  : at least one slot is occupied
//   out_ready  : pop accept
//   out_data   : minimum occupied key ('0 when empty)
//   out_aux    : payload of the minimum entry ('0 when empty)
//   out_slot   : slot index of the minimum entry ('0 when empty)
//   occupancy  : number of occupied slots
// -----------------------------------------------------------------------------
module hs_arith_umin_slot_scheduler #(
    parameter int  DATA_WIDTH    = 32,
    parameter int  SLOT_NUM      = 4,
    parameter type AUX_DATA_TYPE = logic,
    localparam int INDEX_WIDTH   = $clog2(SLOT_NUM),
    localparam int OCC_WIDTH     = $clog2(SLOT_NUM + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  AUX_DATA_TYPE           in_aux,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output AUX_DATA_TYPE           out_aux,
    output logic [INDEX_WIDTH-1:0] out_slot,
    output logic [OCC_WIDTH-1:0]   occupancy
);

    // Registered slot storage.
    logic [SLOT_NUM-1:0]    occ_r;
    logic [DATA_WIDTH-1:0]  key_r [SLOT_NUM];
    AUX_DATA_TYPE           aux_r [SLOT_NUM];
    logic [OCC_WIDTH-1:0]   cnt_r;

    // Selector and allocator results.
    logic                   sel_found_s;
    logic [DATA_WIDTH-1:0]  sel_key_s;
    AUX_DATA_TYPE           sel_aux_s;
    logic [INDEX_WIDTH-1:0] sel_idx_s;
    logic                   free_found_s;
    logic [INDEX_WIDTH-1:0] free_idx_s;
    logic                   full_s;
    logic                   push_s;
    logic                   pop_s;

    // Unsigned minimum selector.
    // A strict less-than keeps the earlier (lower-index) slot on equal keys.
    always_comb begin
        sel_found_s = 1'b0;
        sel_key_s   = '0;
        sel_aux_s   = '0;
        sel_idx_s   = '0;
        for (int i = 0; i < SLOT_NUM; i++) begin
            if (occ_r[i] && (!sel_found_s || (key_r[i] < sel_key_s))) begin
                sel_found_s = 1'b1;
                sel_key_s   = key_r[i];
                sel_aux_s   = aux_r[i];
                sel_idx_s   = INDEX_WIDTH'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Lowest-index free slot allocator, based on start-of-cycle flags.
    always_comb begin
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = 0; i < SLOT_NUM; i++) begin
            if (!occ_r[i] && !free_found_s) begin
                free_found_s = 1'b1;
                free_idx_s   = INDEX_WIDTH'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Handshake qualification.
    // Flush overrides both push and pop in the same cycle.
    always_comb begin
        full_s    = &occ_r;
        in_ready  = !full_s && !flush;
        out_valid = (cnt_r != {OCC_WIDTH{1'b0}});
        push_s    = in_valid && in_ready;
        pop_s     = out_valid && out_ready && !flush;
        out_data  = sel_key_s;
        out_aux   = sel_aux_s;
        out_slot  = sel_idx_s;
        occupancy = cnt_r;
    end

    // Slot flag and occupancy update.
    // A pop frees the selected slot and a push fills a slot that was free
    // at the start of the cycle, so the two never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r <= '0;
            cnt_r <= '0;
        end else if (flush) begin
            occ_r <= '0;
            cnt_r <= '0;
        end else begin
            if (push_s) begin
                occ_r[free_idx_s] <= 1'b1;
            end
            if (pop_s) begin
                occ_r[sel_idx_s] <= 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + OCC_WIDTH'(1);
                2'b01:   cnt_r <= cnt_r - OCC_WIDTH'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Key and payload storage.
    // Flush leaves key and payload contents untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOT_NUM; i++) begin
                key_r[i] <= '0;
                aux_r[i] <= '0;
            end
        end else if (push_s && !flush) begin
            key_r[free_idx_s] <= in_data;
            aux_r[free_idx_s] <= in_aux;
        end
    end

endmodule

// File: tb/tb_hs_arith_umin_slot_scheduler.sv
// -----------------------------------------------------------------------------
// tb_hs_arith_umin_slot_scheduler
//
// Self-checking bench for hs_arith_umin_slot_scheduler (DATA_WIDTH=8,
// SLOT_NUM=4, 8-bit payload). A behavioural slot table models the design.
// Every cycle, the design outputs are compared with values derived from
// that table. Directed scenarios come first, followed by a random run.
// -----------------------------------------------------------------------------
module tb_hs_arith_umin_slot_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_aux;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_aux;
    logic [1:0] out_slot;
    logic [2:0] occupancy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: which slots hold something, and what they hold.
    bit         m_occ [4];
    logic [7:0] m_key [4];
    logic [7:0] m_aux [4];

    always #5 clk = ~clk;

    hs_arith_umin_slot_scheduler #(
        .DATA_WIDTH    (8),
        .SLOT_NUM      (4),
        .AUX_DATA_TYPE (logic [7:0])
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_aux    (in_aux),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_aux   (out_aux),
        .out_slot  (out_slot),
        .occupancy (occupancy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 4; i++) if (m_occ[i]) c++;
        return c;
    endfunction

    // Smallest key wins; on equal keys the first slot found is kept.
    function automatic int m_min_idx();
        int best = -1;
        for (int i = 0; i < 4; i++) begin
            if (m_occ[i]) begin
                if (best < 0) best = i;
                else if (m_key[i] < m_key[best]) best = i;
            end
        end
        return best;
    endfunction

    function automatic int m_free_idx();
        for (int i = 0; i < 4; i++) if (!m_occ[i]) return i;
        return -1;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 4; i++) m_occ[i] = 1'b0;
    endfunction

    // Compare every output against the model, using the inputs currently applied.
    task automatic check_outputs(input string tag);
        int mi;
        int cnt;
        mi  = m_min_idx();
        cnt = m_count();
        check_val({tag, ".in_ready"}, in_ready, (cnt < 4) && !flush);
        check_val({tag, ".out_valid"}, out_valid, mi >= 0);
        check_val({tag, ".occupancy"}, occupancy, cnt);
        if (mi >= 0) begin
            check_val({tag, ".out_data"}, out_data, m_key[mi]);
            check_val({tag, ".out_aux"}, out_aux, m_aux[mi]);
            check_val({tag, ".out_slot"}, out_slot, mi);
        end else begin
            check_val({tag, ".out_data"}, out_data, 32'd0);
            check_val({tag, ".out_aux"}, out_aux, 32'd0);
            check_val({tag, ".out_slot"}, out_slot, 32'd0);
        end
    endtask

    // One clock cycle: apply inputs, check outputs, advance the model, then clock.
    task automatic cycle(input string tag, input bit iv, input logic [7:0] d,
                         input logic [7:0] a, input bit ordy, input bit fl);
        int  mi;
        int  fi;
        bit  push;
        bit  pop;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_aux    = a;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs(tag);
        mi   = m_min_idx();
        fi   = m_free_idx();
        push = iv && (fi >= 0) && !fl;
        pop  = (mi >= 0) && ordy && !fl;
        if (fl) begin
            m_clear();
        end else begin
            if (pop) m_occ[mi] = 1'b0;
            if (push) begin
                m_occ[fi] = 1'b1;
                m_key[fi] = d;
                m_aux[fi] = a;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic push(input string tag, input logic [7:0] d, input logic [7:0] a);
        cycle(tag, 1'b1, d, a, 1'b0, 1'b0);
    endtask

    // Reset assertion mid-stream: outputs must clear without waiting for a clock edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'h11;
        in_aux    = 8'h22;
        out_ready = 1'b1;
        flush     = 1'b0;
        rst_n     = 1'b0;
        #1;
        m_clear();
        check_val({tag, ".out_valid"}, out_valid, 32'd0);
        check_val({tag, ".occupancy"}, occupancy, 32'd0);
        check_val({tag, ".out_data"}, out_data, 32'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs({tag, ".post"});
        check_val({tag, ".in_ready"}, in_ready, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_aux    = 8'h00;
        out_ready = 1'b0;
        m_clear();
        for (int i = 0; i < 4; i++) begin
            m_key[i] = 8'h00;
            m_aux[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1;
        check_val("reset.out_valid", out_valid, 32'd0);
        check_val("reset.occupancy", occupancy, 32'd0);
        check_val("reset.in_ready", in_ready, 32'd1);
        check_val("reset.out_data", out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Minimum selection without popping.
        push("s35", 8'h30, 8'hA0);
        push("s35", 8'h10, 8'hA1);
        push("s35", 8'h20, 8'hA2);
        check_val("s35.out_data", out_data, 32'h10);
        check_val("s35.out_slot", out_slot, 32'd1);
        check_val("s35.occupancy", occupancy, 32'd3);
        idle("s35.hold");
        cycle("s35.flush", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Fill, then drain in key order with lower slot first on ties.
        push("s36", 8'h05, 8'hB0);
        push("s36", 8'h09, 8'hB1);
        push("s36", 8'h05, 8'hB2);
        push("s36", 8'h07, 8'hB3);
        check_val("s36.in_ready", in_ready, 32'd0);
        check_val("s36.occupancy", occupancy, 32'd4);
        check_val("s36.pop0_data", out_data, 32'h05);
        check_val("s36.pop0_slot", out_slot, 32'd0);
        cycle("s36.pop", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_val("s36.pop1_data", out_data, 32'h05);
        check_val("s36.pop1_slot", out_slot, 32'd2);
        cycle("s36.pop", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_val("s36.pop2_data", out_data, 32'h07);
        cycle("s36.pop", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_val("s36.pop3_data", out_data, 32'h09);
        cycle("s36.pop", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_val("s36.empty_valid", out_valid, 32'd0);
        cycle("s36.pop_empty", 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Full with push and pop together: the push is rejected.
        push("s37", 8'h40, 8'hC0);
        push("s37", 8'h08, 8'hC1);
        push("s37", 8'h50, 8'hC2);
        push("s37", 8'h60, 8'hC3);
        cycle("s37.both", 1'b1, 8'h01, 8'hCC, 1'b1, 1'b0);
        check_val("s37.occupancy", occupancy, 32'd3);
        push("s37.refill", 8'h02, 8'hCD);
        check_val("s37.refill_slot", out_slot, 32'd1);
        check_val("s37.refill_data", out_data, 32'h02);
        cycle("s37.flush", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Push and pop in the same cycle at occupancy 2.
        push("s38", 8'h20, 8'hD0);
        push("s38", 8'h30, 8'hD1);
        cycle("s38.both", 1'b1, 8'h01, 8'hD2, 1'b1, 1'b0);
        check_val("s38.occupancy", occupancy, 32'd2);
        check_val("s38.out_data", out_data, 32'h01);
        check_val("s38.out_slot", out_slot, 32'd2);
        idle("s38.after");

        // Flush takes priority over push and pop.
        push("s39", 8'h44, 8'hE0);
        cycle("s39.flush", 1'b1, 8'h02, 8'hE1, 1'b1, 1'b1);
        check_val("s39.occupancy", occupancy, 32'd0);
        check_val("s39.out_valid", out_valid, 32'd0);
        idle("s39.after");
        check_val("s39.in_ready", in_ready, 32'd1);

        // Reset assertion in the middle of traffic.
        push("s40", 8'h70, 8'hF0);
        push("s40", 8'h60, 8'hF1);
        check_val("s40.pre_occupancy", occupancy, 32'd2);
        do_reset("s40.reset");
        push("s40.first", 8'h55, 8'hF2);
        check_val("s40.first_slot", out_slot, 32'd0);
        check_val("s40.first_data", out_data, 32'h55);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle("rand", ($urandom_range(0, 99) < 60),
                  8'($urandom_range(0, 15)), 8'($urandom),
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 4));
        end
        idle("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
